// File: rtl/spart_rx.sv
// SPART receive stage: deserialises 8N1 frames from rxd using the baud
// generator's 16x oversampling tick and flags data-available, framing error and overrun.
module spart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rxd,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LINE_BREAK
  } state_t;

  state_t               state;
  logic                 rxd_m;
  logic                 rxd_s;
  logic [CNT_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 mid_start;
  logic                 mid_bit;
  logic                 frame_done;

  // The synchroniser resets to the idle line level so reset release never
  // looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      // NOTE: non-blocking here makes rxd_s take the previous rxd_m, giving two real flop stages.
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  assign mid_start  = (tick_cnt == CNT_W'(OVERSAMPLE / 2 - 1));
  assign mid_bit    = (tick_cnt == CNT_W'(OVERSAMPLE - 1));
  assign frame_done = baud_tick && (state == STOP) && mid_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else if (baud_tick) begin
      case (state)
        IDLE: begin
          if (!rxd_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (mid_start) begin
            if (!rxd_s) begin
              state    <= DATA;
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (mid_bit) begin
            shift    <= {rxd_s, shift[DATA_BITS-1:1]};
            tick_cnt <= '0;
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (mid_bit) begin
            tick_cnt <= '0;
            state    <= rxd_s ? IDLE : LINE_BREAK;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        LINE_BREAK: begin
          // A held-low line must return high before a new start bit counts.
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion wins over a coincident read; a read only clears the flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else if (frame_done) begin
      rx_data     <= shift;
      rda         <= 1'b1;
      framing_err <= ~rxd_s;
      overrun     <= (overrun | rda) & ~rd_en;
    end else if (rd_en && rda) begin
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: directed frames plus random frames
// compared against a frame-level model of the receive buffer flags.
module tb_spart_rx;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rx_data;
  logic       rda;
  logic       framing_err;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_data = 8'h00;
  logic       m_rda = 1'b0;
  logic       m_fe = 1'b0;
  logic       m_ovr = 1'b0;

  spart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rxd         (rxd),
    .rd_en       (rd_en),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_data"}, 32'(rx_data), 32'(m_data));
    check({tag, "_rda"}, 32'(rda), 32'(m_rda));
    check({tag, "_fe"}, 32'(framing_err), 32'(m_fe));
    check({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  // Frame-level model of the receive buffer.
  function automatic void model_frame(input logic [7:0] d, input bit stop_ok, input bit rd);
    m_ovr  = rd ? 1'b0 : (m_ovr | m_rda);
    m_data = d;
    m_rda  = 1'b1;
    m_fe   = !stop_ok;
  endfunction

  function automatic void model_read();
    if (m_rda) begin
      m_rda = 1'b0;
      m_fe  = 1'b0;
      m_ovr = 1'b0;
    end
  endfunction

  // One baud tick every 4 clks; the line level is set well before the tick.
  task automatic do_tick(input logic level, input logic rd);
    @(negedge clk) rxd = level;
    repeat (2) @(negedge clk);
    baud_tick = 1'b1;
    rd_en     = rd;
    @(negedge clk);
    baud_tick = 1'b0;
    rd_en     = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b1, 1'b0);
  endtask

  task automatic do_read();
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
    model_read();
  endtask

  // Sends one frame, OS ticks per bit. stop_low: ticks the stop bit is held
  // low (0 = clean stop). rd_at/abort_at: tick index or -1.
  task automatic send_frame(input logic [7:0] d, input int stop_low, input int rd_at,
                            input int abort_at);
    int total;
    int sample_t;
    logic level;
    total    = (stop_low > 0) ? (9 * OS + stop_low + OS) : (10 * OS);
    sample_t = 9 * OS + OS / 2;
    for (int t = 0; t < total; t++) begin
      int b;
      if (t == abort_at) return;
      b = t / OS;
      if (b == 0) level = 1'b0;
      else if (b <= 8) level = d[b-1];
      else level = ((t - 9 * OS) < stop_low) ? 1'b0 : 1'b1;
      do_tick(level, t == rd_at);
      if (t == sample_t) begin
        model_frame(d, stop_low <= OS / 2, t == rd_at);
        check("latency_rda", 32'(rda), 32'(m_rda));
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    int stop_low;
    int mode;

    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    idle_ticks(4);

    // Basic frame and read.
    send_frame(8'hA5, 0, -1, -1);
    check_all("a5");
    do_read();
    check_all("a5_read");

    // False start: 4 ticks low then high.
    for (int i = 0; i < 4; i++) do_tick(1'b0, 1'b0);
    idle_ticks(16);
    check_all("false_start");
    send_frame(8'h5A, 0, -1, -1);
    check_all("5a");
    do_read();

    // Framing error with a long break, then a clean frame.
    send_frame(8'h3C, 20, -1, -1);
    check_all("3c_break");
    do_read();
    send_frame(8'h81, 0, -1, -1);
    check_all("81");
    do_read();

    // Overrun, then a read clears everything.
    send_frame(8'h11, 0, -1, -1);
    send_frame(8'h22, 0, -1, -1);
    check_all("overrun");
    do_read();
    check_all("overrun_read");

    // Read coincident with the stop-sample tick of a second frame.
    send_frame(8'h33, 0, -1, -1);
    send_frame(8'h7E, 0, 9 * OS + OS / 2, -1);
    check_all("coincident");
    do_read();

    // Random frames with random reads, stop-bit faults and gaps.
    for (int i = 0; i < 16; i++) begin
      d        = 8'($urandom);
      stop_low = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 24)) : 0;
      mode     = int'($urandom_range(0, 3));
      idle_ticks(int'($urandom_range(0, 3)));
      send_frame(d, stop_low, (mode == 3) ? (9 * OS + OS / 2) : -1, -1);
      check_all($sformatf("rand%0d", i));
      if (mode <= 1) begin
        do_read();
        check_all($sformatf("rand%0d_read", i));
      end
    end

    // Reset in the middle of data bit 4 of 0xFF.
    send_frame(8'h6C, 0, -1, -1);
    send_frame(8'hFF, 0, -1, 5 * OS + OS / 2);
    @(negedge clk) rst = 1'b0;
    #1;
    m_data = 8'h00;
    m_rda  = 1'b0;
    m_fe   = 1'b0;
    m_ovr  = 1'b0;
    check_all("mid_reset");
    rxd = 1'b1;
    @(negedge clk) rst = 1'b1;
    idle_ticks(4);
    check_all("after_reset");
    send_frame(8'h00, 0, -1, -1);
    check_all("zero");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spart_rx.md
Name: spart_rx

Overview:
- Serial receive stage of the SPART, directly downstream of the baud generator.
- Consumes the baud generator's one-clk baud_clk pulse as a 16x oversampling tick.
- Deserialises 8N1 frames from the rxd pin into a one-byte holding register.
- Flags receive-data-available, framing error and overrun to the bus interface.

Parameters:
OVERSAMPLE, 16, baud ticks per bit period (even, >= 4)
DATA_BITS, 8, data bits per frame; LSB first

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
baud_tick  input  1  one-clk pulse from baud generator; all bit timing counts these
rxd  input  1  asynchronous serial line, idle high
rd_en  input  1  one-clk bus read strobe of the receive buffer
rx_data  output  DATA_BITS  last received byte
rda  output  1  receive data available
framing_err  output  1  stop bit of the byte in rx_data sampled low
overrun  output  1  a byte was overwritten before being read

Behaviour:
- Reset values (async, rst low):
  - rx_data=0, rda=0, framing_err=0, overrun=0.
  - Synchroniser flops = 1, state=IDLE, tick counter=0, bit counter=0, shift register=0.
- rxd passes through a 2-flop synchroniser (rxd_s); all decisions use rxd_s only.
- The FSM and counters advance only on clk edges with baud_tick=1. With baud_tick=0, all state holds.
- Tick counter: 4 bits (log2 OVERSAMPLE); bit counter: 3 bits (log2 DATA_BITS).
- IDLE: on tick with rxd_s=0 -> START, tick counter=0.
- START: increment per tick. When counter reaches OVERSAMPLE/2-1 (mid start bit):
  - rxd_s=0 -> DATA, tick counter=0, bit counter=0.
  - rxd_s=1 -> false start; back to IDLE, no flags change.
- DATA: increment per tick. On the tick where counter = OVERSAMPLE-1 (mid bit):
  - Shift rxd_s into shift register MSB (shift right), clear tick counter.
  - After bit DATA_BITS-1 -> STOP; otherwise bit counter+1.
- STOP: on tick where counter = OVERSAMPLE-1, complete the frame:
  - rx_data <= shift register; rda <= 1; framing_err <= ~rxd_s.
  - rxd_s=1 -> IDLE; rxd_s=0 -> BREAK.
- BREAK: stay until a tick with rxd_s=1, then IDLE. No new start bit is accepted while low.
- Latency: outputs update on the clk edge of the stop-sample tick, visible the following cycle.
- Overrun: frame completes while rda=1 and rd_en=0 -> rx_data overwritten, overrun <= 1 (sticky).
- rd_en alone: next edge rda=0, framing_err=0, overrun=0.
- rd_en coincident with frame completion:
  - Completion wins: rda stays 1, rx_data = new byte, framing_err from new frame.
  - overrun cleared, not set.
- rd_en with rda=0: no effect.
- rxd changes between ticks are ignored; rxd activity never alters outputs except via frame completion.
- Reset mid-frame: immediate return to the reset values above; the partial frame is discarded.

Test Plan:
- Drive baud_tick every 4 clks; send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), 16 ticks/bit -> rda=1, rx_data=0xA5, framing_err=0, overrun=0. Then rd_en pulse -> rda=0 next cycle.
- rxd low for 4 ticks then high -> FSM returns to IDLE, rda stays 0; a following 0x5A frame is received correctly.
- Send 0x3C with stop bit held 0 for 20 ticks, then high -> rx_data=0x3C, framing_err=1, rda=1. No false frame while low; next frame 0x81 received correctly.
- Send 0x11 then 0x22 back-to-back without reading -> rx_data=0x22, rda=1, overrun=1. rd_en -> all three flags 0.
- Pulse rd_en on the exact stop-sample tick of a second frame 0x7E (first byte unread) -> rda=1, rx_data=0x7E, overrun=0.
- Assert rst low during data bit 4 of 0xFF -> all outputs 0 immediately. After release, 0x00 frame -> rx_data=0x00, rda=1, framing_err=0.
